// File: rtl/rgb_fader.sv
// Ramps three 8-bit PWM levels toward a handshaken RGB target, one STEP every RAMP_DIV PWM periods.
// Optional build macro RGB_FADER_RETARGET_EN keeps tgt_ready high during a ramp so targets can be replaced.
module rgb_fader #(
  parameter int RAMP_DIV = 4,
  parameter int STEP     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tgt_r,
  input  logic [7:0] tgt_g,
  input  logic [7:0] tgt_b,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  output logic [7:0] level_r,
  output logic [7:0] level_g,
  output logic [7:0] level_b,
  output logic       busy,
  output logic       period_end,
  output logic       state_dbg
);

  // Handshake: a target triple transfers on any rising edge where tgt_valid && tgt_ready;
  // tgt_valid may be asserted at any time, tgt_ready never depends on tgt_valid.

  localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DW-1:0] DLAST = DW'(RAMP_DIV - 1);
  localparam logic [8:0] STEP9 = 9'(STEP);

  typedef enum logic {S_IDLE = 1'b0, S_RAMP = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [7:0]    pcnt;
  logic [DW-1:0] dcnt;
  logic [7:0]    tr, tg, tb;
  logic [7:0]    lr, lg, lb;
  logic [7:0]    nr, ng, nb;
  logic [7:0]    ntr, ntg, ntb;
  logic          hs, step_ev;

  // Bounded move of cur toward tgt; 9-bit arithmetic so the clamp never wraps.
  function automatic logic [7:0] ramp_step(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] c9, t9, d9, r9;
    c9 = {1'b0, cur};
    t9 = {1'b0, tgt};
    d9 = '0;
    r9 = c9;
    if (c9 < t9) begin
      d9 = t9 - c9;
      r9 = c9 + ((d9 < STEP9) ? d9 : STEP9);
    end else if (c9 > t9) begin
      d9 = c9 - t9;
      r9 = c9 - ((d9 < STEP9) ? d9 : STEP9);
    end
    return r9[7:0];
  endfunction

  assign period_end = (pcnt == 8'hff);
  assign hs         = tgt_valid && tgt_ready;
  assign step_ev    = (state == S_RAMP) && period_end && (dcnt == DLAST);

  always_comb begin
    nr  = lr;
    ng  = lg;
    nb  = lb;
    ntr = tr;
    ntg = tg;
    ntb = tb;
    // A step always uses the targets held before this edge.
    if (step_ev) begin
      nr = ramp_step(lr, tr);
      ng = ramp_step(lg, tg);
      nb = ramp_step(lb, tb);
    end
    if (hs) begin
      ntr = tgt_r;
      ntg = tgt_g;
      ntb = tgt_b;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (hs && ({tgt_r, tgt_g, tgt_b} != {lr, lg, lb})) state_nxt = S_RAMP;
      S_RAMP: if ({nr, ng, nb} == {ntr, ntg, ntb}) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = reset && (state == S_RAMP);
`ifdef RGB_FADER_RETARGET_EN
    tgt_ready = reset;
`else
    tgt_ready = reset && (state == S_IDLE);
`endif
    state_dbg = state;
    level_r   = lr;
    level_g   = lg;
    level_b   = lb;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pcnt <= 8'd0;
      dcnt <= '0;
      tr   <= 8'd0;
      tg   <= 8'd0;
      tb   <= 8'd0;
      lr   <= 8'd0;
      lg   <= 8'd0;
      lb   <= 8'd0;
    end else begin
      pcnt <= pcnt + 8'd1;
      tr   <= ntr;
      tg   <= ntg;
      tb   <= ntb;
      lr   <= nr;
      lg   <= ng;
      lb   <= nb;
      // A retarget inside RAMP leaves dcnt alone so the step cadence is kept.
      if (state == S_IDLE && state_nxt == S_RAMP) dcnt <= '0;
      else if (state == S_RAMP && period_end)     dcnt <= step_ev ? '0 : dcnt + DW'(1);
    end
  end

endmodule

// File: tb/tb_rgb_fader.sv
// Directed bench for rgb_fader: three instances with different RAMP_DIV/STEP share clock, reset and target bus.
module tb_rgb_fader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

`ifdef RGB_FADER_RETARGET_EN
  localparam bit RT = 1'b1;
`else
  localparam bit RT = 1'b0;
`endif

  logic [7:0] tgt_r = 8'd0, tgt_g = 8'd0, tgt_b = 8'd0;
  logic valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;

  logic       ready_a, ready_b, ready_c;
  logic [7:0] lr_a, lg_a, lb_a, lr_b, lg_b, lb_b, lr_c, lg_c, lb_c;
  logic       busy_a, busy_b, busy_c;
  logic       pe_a, pe_b, pe_c;
  logic       st_a, st_b, st_c;

  rgb_fader #(.RAMP_DIV(1), .STEP(16)) dut_a (
    .clk(clk), .reset(reset), .tgt_r(tgt_r), .tgt_g(tgt_g), .tgt_b(tgt_b),
    .tgt_valid(valid_a), .tgt_ready(ready_a), .level_r(lr_a), .level_g(lg_a), .level_b(lb_a),
    .busy(busy_a), .period_end(pe_a), .state_dbg(st_a));

  rgb_fader #(.RAMP_DIV(4), .STEP(1)) dut_b (
    .clk(clk), .reset(reset), .tgt_r(tgt_r), .tgt_g(tgt_g), .tgt_b(tgt_b),
    .tgt_valid(valid_b), .tgt_ready(ready_b), .level_r(lr_b), .level_g(lg_b), .level_b(lb_b),
    .busy(busy_b), .period_end(pe_b), .state_dbg(st_b));

  rgb_fader #(.RAMP_DIV(1), .STEP(100)) dut_c (
    .clk(clk), .reset(reset), .tgt_r(tgt_r), .tgt_g(tgt_g), .tgt_b(tgt_b),
    .tgt_valid(valid_c), .tgt_ready(ready_c), .level_r(lr_c), .level_g(lg_c), .level_b(lb_c),
    .busy(busy_c), .period_end(pe_c), .state_dbg(st_c));

  int checks = 0;
  int failures = 0;
  int pe_err = 0;

  // Reference PWM period position, counted independently of the DUTs.
  logic [7:0] bpcnt = 8'd0;
  always @(posedge clk) bpcnt <= reset ? bpcnt + 8'd1 : 8'd0;

  always @(negedge clk) begin
    if (pe_a !== (bpcnt == 8'hff) || pe_b !== (bpcnt == 8'hff) || pe_c !== (bpcnt == 8'hff))
      pe_err++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Advance to the negedge of the n-th following pcnt==0 cycle.
  task automatic wait_periods(input int n);
    repeat (n) begin
      int g = 0;
      @(negedge clk);
      while (bpcnt != 8'd0 && g < 300) begin
        @(negedge clk);
        g++;
      end
      if (g >= 300) check("wait_timeout", 1, 0);
    end
  endtask

  task automatic load(input int which, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    tgt_r = r;
    tgt_g = g;
    tgt_b = b;
    case (which)
      0: begin check("ready_a_at_load", ready_a, 1); valid_a = 1'b1; end
      1: begin check("ready_b_at_load", ready_b, 1); valid_b = 1'b1; end
      default: begin check("ready_c_at_load", ready_c, 1); valid_c = 1'b1; end
    endcase
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    valid_c = 1'b0;
  endtask

  typedef struct {
    bit         load;
    logic [7:0] r, g, b;
    int         periods;
    logic [7:0] er, eg, eb;
    bit         ebusy;
  } vec_t;

  vec_t va[12];

  initial begin
    int first_pe;

    // Instance A: RAMP_DIV=1, STEP=16
    va[0]  = '{1'b1, 8'd40, 8'd0,   8'd255, 1,  8'd40, 8'd0,   8'd16,  1'b1};
    va[0].er = 8'd16;
    va[1]  = '{1'b0, 8'd0,  8'd0,   8'd0,   1,  8'd32, 8'd0,   8'd32,  1'b1};
    va[2]  = '{1'b0, 8'd0,  8'd0,   8'd0,   1,  8'd40, 8'd0,   8'd48,  1'b1};
    va[3]  = '{1'b0, 8'd0,  8'd0,   8'd0,   12, 8'd40, 8'd0,   8'd240, 1'b1};
    va[4]  = '{1'b0, 8'd0,  8'd0,   8'd0,   1,  8'd40, 8'd0,   8'd255, 1'b0};
    va[5]  = '{1'b1, 8'd40, 8'd0,   8'd255, 0,  8'd40, 8'd0,   8'd255, 1'b0};
    va[6]  = '{1'b1, 8'd0,  8'd100, 8'd250, 0,  8'd40, 8'd0,   8'd255, 1'b1};
    va[7]  = '{1'b0, 8'd0,  8'd0,   8'd0,   1,  8'd24, 8'd16,  8'd250, 1'b1};
    va[8]  = '{1'b0, 8'd0,  8'd0,   8'd0,   1,  8'd8,  8'd32,  8'd250, 1'b1};
    va[9]  = '{1'b0, 8'd0,  8'd0,   8'd0,   1,  8'd0,  8'd48,  8'd250, 1'b1};
    va[10] = '{1'b0, 8'd0,  8'd0,   8'd0,   3,  8'd0,  8'd96,  8'd250, 1'b1};
    va[11] = '{1'b0, 8'd0,  8'd0,   8'd0,   1,  8'd0,  8'd100, 8'd250, 1'b0};

    // Reset and release
    repeat (3) @(negedge clk);
    check("reset_levels", {lr_a, lg_a, lb_a}, 24'd0);
    check("reset_ready_busy", {ready_a, busy_a, pe_a}, 3'b000);
    reset = 1'b1;
    #1;
    check("release_ready", ready_a, 1);
    first_pe = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) check("ready_cycle1", {ready_a, busy_a, lr_a}, {1'b1, 1'b0, 8'd0});
      if (pe_a && first_pe < 0) first_pe = k;
    end
    check("first_period_end", first_pe, 255);
    wait_periods(1);

    // Table-driven ramp sequence on instance A
    for (int i = 0; i < 12; i++) begin
      if (va[i].load) load(0, va[i].r, va[i].g, va[i].b);
      wait_periods(va[i].periods);
      check($sformatf("vec_a[%0d]", i), {lr_a, lg_a, lb_a, busy_a, ready_a},
            {va[i].er, va[i].eg, va[i].eb, va[i].ebusy, (!va[i].ebusy) || RT});
    end

    // Instance B: RAMP_DIV=4, STEP=1, red 0 -> 2; steps land exactly at the pcnt wrap
    load(1, 8'd2, 8'd0, 8'd0);
    check("b_busy_after_load", busy_b, 1);
    wait_periods(3);
    check("b_no_step_yet", {lr_b, busy_b}, {8'd0, 1'b1});
    while (bpcnt != 8'hff) @(negedge clk);
    check("b_hold_at_255", lr_b, 8'd0);
    @(negedge clk);
    check("b_step1_at_wrap", {lr_b, lg_b, lb_b, busy_b}, {8'd1, 8'd0, 8'd0, 1'b1});
    wait_periods(3);
    check("b_hold_between", lr_b, 8'd1);
    wait_periods(1);
    check("b_done", {lr_b, busy_b, ready_b}, {8'd2, 1'b0, 1'b1});

    // Instance C: STEP=100 up then down, then equal targets held valid
    load(2, 8'd200, 8'd0, 8'd0);
    wait_periods(2);
    check("c_up", {lr_c, busy_c}, {8'd200, 1'b0});
    load(2, 8'd0, 8'd0, 8'd0);
    wait_periods(1);
    check("c_down1", {lr_c, busy_c}, {8'd100, 1'b1});
    wait_periods(1);
    check("c_down2", {lr_c, busy_c}, {8'd0, 1'b0});
    tgt_r = 8'd0; tgt_g = 8'd0; tgt_b = 8'd0;
    valid_c = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("c_equal_hold[%0d]", k), {busy_c, ready_c, lr_c, st_c}, {1'b1 ^ 1'b1, 1'b1, 8'd0, 1'b0});
    end
    valid_c = 1'b0;

`ifdef RGB_FADER_RETARGET_EN
    // Retarget mid-ramp: 32 heading for 200, new target 0
    load(0, 8'd200, 8'd100, 8'd250);
    wait_periods(2);
    check("rt_at_32", {lr_a, busy_a, ready_a}, {8'd32, 1'b1, 1'b1});
    load(0, 8'd0, 8'd100, 8'd250);
    check("rt_still_busy", {lr_a, busy_a}, {8'd32, 1'b1});
    wait_periods(1);
    check("rt_step_down", {lr_a, busy_a}, {8'd16, 1'b1});
    wait_periods(1);
    check("rt_done", {lr_a, busy_a}, {8'd0, 1'b0});
    load(0, 8'd200, 8'd100, 8'd250);
    wait_periods(3);
`else
    // Targets frozen during a ramp: an offered triple is not accepted
    load(0, 8'd200, 8'd100, 8'd250);
    wait_periods(1);
    tgt_r = 8'd0;
    valid_a = 1'b1;
    check("frozen_ready_low", ready_a, 0);
    @(negedge clk);
    valid_a = 1'b0;
    wait_periods(1);
    check("frozen_keeps_ramp", {lr_a, busy_a}, {8'd32, 1'b1});
    wait_periods(1);
`endif
    check("a_at_48", {lr_a, busy_a}, {8'd48, 1'b1});

    // Reset mid-ramp with a simultaneous handshake attempt
    reset = 1'b0;
    tgt_r = 8'd99; tgt_g = 8'd99; tgt_b = 8'd99;
    valid_a = 1'b1;
    @(negedge clk);
    check("midreset_state", {lr_a, lg_a, lb_a, busy_a, ready_a, st_a}, {24'd0, 1'b0, 1'b0, 1'b0});
    valid_a = 1'b0;
    reset = 1'b1;
    #1;
    check("midreset_release_ready", ready_a, 1);
    @(negedge clk);
    check("midreset_idle", {lr_a, busy_a, st_a}, {8'd0, 1'b0, 1'b0});

    check("period_end_align", pe_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/rgb_fader.md
# rgb_fader

Level controller for the three 8-bit PWM channels of the RGB mixer. Accepts a red/green/blue target triple over a valid/ready handshake and ramps each channel's current level toward its target by a fixed step every N PWM periods. Level changes are applied only at PWM period boundaries, so no PWM period is ever truncated or stretched. Sits between the input/encoder logic and the three `pwm` instances, whose `level` inputs it drives.

## Interface
- `RAMP_DIV`, 4: PWM periods (256 clocks each) per ramp step; legal 1..256.
- `STEP`, 1: maximum level change per channel per ramp step; legal 1..255.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `tgt_r`, `tgt_g`, `tgt_b`  in  8 each  target levels; sampled on handshake.
- `tgt_valid`  in  1  target triple valid.
- `tgt_ready`  out  1  block can accept a target triple.
- `level_r`, `level_g`, `level_b`  out  8 each  current levels to the PWM `level` inputs.
- `busy`  out  1  high while any channel differs from its target.
- `period_end`  out  1  high during the last clock of each 256-clock PWM period.

## Operation
- Period counter: 8-bit free-running `pcnt`, 0 in reset, +1 per clock, wraps 255→0. It is aligned with the PWM counters, which are reset by the same reset. `period_end` = (`pcnt`==255).
- Target registers `tr`/`tg`/`tb`. Handshake: (`tgt_valid` && `tgt_ready`) on edge t loads all three. There is no partial load.
- States:
  - IDLE: `tgt_ready`=1, `busy`=0. After a handshake, go to RAMP if any loaded target ≠ its level; otherwise stay in IDLE.
  - RAMP: `busy`=1. `tgt_ready`=0, unless RGB_FADER_RETARGET_EN is defined.
- Divider `dcnt` (width clog2(RAMP_DIV), min 1): cleared on entry to RAMP; increments on each `period_end` cycle while in RAMP.
- Step event: `period_end` && `dcnt`==RAMP_DIV-1 in RAMP. On a step event, `dcnt` returns to 0.
- Per-channel update on a step event:
  - cur<tgt: cur += min(STEP, tgt−cur).
  - cur>tgt: cur −= min(STEP, cur−tgt).
  - equal: hold.
  - Compute in 9 bits. The result never overshoots, so no wrap past 0 or 255 is possible.
- Exit from RAMP: on the step event that makes all three channels equal their targets, state → IDLE on the same edge.
- Levels change only on step events; at all other times they hold.

## Timing
- Reset: `level_*`=0, `tr`/`tg`/`tb`=0, `pcnt`=0, `dcnt`=0, state IDLE. While `reset`=0: `tgt_ready`=0 and `busy`=0. `tgt_ready`=1 on the first cycle after release.
- Handshake at edge t → `busy`=1 from cycle t+1 (if a ramp is needed).
- Level updates on the edge that ends a `pcnt`==255 cycle, so the new level first applies at `pcnt`==0.
- First step occurs at the RAMP_DIV-th `period_end` after entering RAMP. Subsequent steps occur every RAMP_DIV·256 clocks.
- Reset asserted mid-ramp: all state returns to reset values on that edge. A pending handshake in the same cycle is ignored.
- `tgt_valid` held high in IDLE with equal targets: each cycle is a handshake; no state change.

## Configuration
- `RGB_FADER_RETARGET_EN` defined:
  - `tgt_ready`=1 in RAMP as well.
  - A handshake in RAMP replaces the targets; `dcnt` is not cleared, so the step cadence is preserved.
  - If the new targets equal the current levels, go to IDLE on the next edge.
  - A handshake on a step-event cycle: the step uses the old targets, and the new targets load on the same edge. The exit check on that edge uses the new targets.
- `RGB_FADER_RETARGET_EN` not defined: `tgt_ready`=0 throughout RAMP; targets are frozen until IDLE.

## Test plan
- Reset release: all levels 0, `tgt_ready`=1 on the next cycle, `period_end` first high at cycle 255 after release.
- RAMP_DIV=1, STEP=16, targets (40,0,255) from 0: red goes 16, 32, 40; blue goes +16 per period to 255 after 16 periods. Level changes coincide with `pcnt` wrapping to 0. `busy` falls on the 16th step.
- RAMP_DIV=4, STEP=1, target red=2 from 0: red=1 after 1024 clocks, red=2 after 2048 clocks, then IDLE.
- Descending with RAMP_DIV=1, STEP=100: red 200→0 gives 100, 0. Target equal to current: `busy` stays 0.
- Reset asserted mid-ramp at red=48: levels go to 0 and the block is in IDLE on the next cycle.
- With RGB_FADER_RETARGET_EN: at red=32 ramping to 200, retarget to 0. The next step (same cadence) gives 16 with STEP=16. Without the macro, `tgt_ready`=0 until ramp done.
